// File: rtl/mig_arb_pkg.sv
// Shared constants for the MIG request arbiter.
// Command encodings follow the MIG app_cmd LSB.
package mig_arb_pkg;

    localparam logic CMD_WRITE = 1'b0;
    localparam logic CMD_READ  = 1'b1;

    localparam logic MST_CPU = 1'b0;
    localparam logic MST_DMA = 1'b1;

endpackage

// File: rtl/mig_rdtag_fifo.sv
// In-order FIFO of 1-bit master tags for reads
// that are issued but not yet returned.
module mig_rdtag_fifo #(
    parameter int DEPTH = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  logic din_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output logic head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem_q;
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      cnt_q, cnt_d;

    // Pointer and occupancy next-state; pointers wrap modulo DEPTH.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push_i) wptr_d = wptr_q + 1'b1;
        if (pop_i)  rptr_d = rptr_q + 1'b1;
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Tag storage; contents are don't-care while empty.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wptr_q] <= din_i;
    end

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rptr_q];

endmodule

// File: rtl/mig_req_arb.sv
// Two-master round-robin arbiter for the MIG request path,
// with in-order read-data steering back to the issuing master.
module mig_req_arb
    import mig_arb_pkg::*;
#(
    parameter int RDTAG_DEPTH = 8,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 128
) (
    input  logic              mclk,
    input  logic              mrst,
    input  logic              r0_req,
    input  logic              r0_rd_bwt,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ack,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_rd_bwt,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ack,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              req_qwen,
    output logic [ADDR_W-1:0] req_qwaddr,
    output logic              req_qwrd_bwt,
    input  logic              req_wqfull,
    output logic              wdq_wen,
    output logic [DATA_W-1:0] wdq_wdata,
    input  logic              wdq_wqfull,
    output logic              rdq_rnext,
    input  logic              rdq_rqempty,
    input  logic [DATA_W-1:0] rdq_rdata,
    output logic              rd_orphan
);

    logic              elig0, elig1;
    logic              gnt_v, gnt_id;
    logic              rr_q, rr_d;
    logic              sel_rd;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              tag_full, tag_empty, tag_head;
    logic              tag_push, tag_pop;
    logic [1:0]        rv_q, rv_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              orphan_q, orphan_d;

    // A master is eligible only if every queue it will push can take it.
    always_comb begin
        elig0 = ~mrst & r0_req & ~req_wqfull &
                ((r0_rd_bwt == CMD_READ) ? ~tag_full : ~wdq_wqfull);
        elig1 = ~mrst & r1_req & ~req_wqfull &
                ((r1_rd_bwt == CMD_READ) ? ~tag_full : ~wdq_wqfull);
    end

    // Round-robin pick; the pointer always lands on the loser.
    always_comb begin
        gnt_v  = elig0 | elig1;
        gnt_id = MST_CPU;
        if (elig0 & elig1) gnt_id = rr_q;
        else if (elig1)    gnt_id = MST_DMA;
        rr_d = gnt_v ? ~gnt_id : rr_q;
    end

    // Route the winner's command into the request and write-data queues.
    always_comb begin
        sel_rd    = (gnt_id == MST_DMA) ? r1_rd_bwt : r0_rd_bwt;
        sel_addr  = (gnt_id == MST_DMA) ? r1_addr   : r0_addr;
        sel_wdata = (gnt_id == MST_DMA) ? r1_wdata  : r0_wdata;
        r0_ack       = gnt_v & (gnt_id == MST_CPU);
        r1_ack       = gnt_v & (gnt_id == MST_DMA);
        req_qwen     = gnt_v;
        req_qwaddr   = gnt_v ? sel_addr : '0;
        req_qwrd_bwt = gnt_v & sel_rd;
        wdq_wen      = gnt_v & (sel_rd == CMD_WRITE);
        wdq_wdata    = wdq_wen ? sel_wdata : '0;
        tag_push     = gnt_v & (sel_rd == CMD_READ);
    end

    // Pop a beat only when a tag says who owns it; else flag an orphan.
    always_comb begin
        tag_pop  = ~mrst & ~rdq_rqempty & ~tag_empty;
        rv_d     = '0;
        rdata_d  = rdata_q;
        if (tag_pop) begin
            rv_d[tag_head] = 1'b1;
            rdata_d        = rdq_rdata;
        end
        orphan_d = orphan_q | (~rdq_rqempty & tag_empty);
    end

    // Priority pointer, read-return stage and sticky orphan flag.
    always_ff @(posedge mclk) begin
        if (mrst) begin
            rr_q     <= MST_CPU;
            rv_q     <= '0;
            rdata_q  <= '0;
            orphan_q <= 1'b0;
        end else begin
            rr_q     <= rr_d;
            rv_q     <= rv_d;
            rdata_q  <= rdata_d;
            orphan_q <= orphan_d;
        end
    end

    mig_rdtag_fifo #(
        .DEPTH (RDTAG_DEPTH)
    ) u_tags (
        .clk_i   (mclk),
        .rst_i   (mrst),
        .push_i  (tag_push),
        .din_i   (gnt_id),
        .pop_i   (tag_pop),
        .full_o  (tag_full),
        .empty_o (tag_empty),
        .head_o  (tag_head)
    );

    assign rdq_rnext = tag_pop;
    assign r0_rvalid = rv_q[0];
    assign r1_rvalid = rv_q[1];
    assign r0_rdata  = rdata_q;
    assign r1_rdata  = rdata_q;
    assign rd_orphan = orphan_q;

endmodule

// File: tb/tb_mig_req_arb.sv
// Self-checking bench for mig_req_arb: directed scenarios and a
// randomized phase, all checked against a queue-based reference model.
module tb_mig_req_arb;

    localparam int DEPTH = 8;

    logic         mclk, mrst;
    logic         r0_req, r0_rd_bwt, r1_req, r1_rd_bwt;
    logic [31:0]  r0_addr, r1_addr;
    logic [127:0] r0_wdata, r1_wdata;
    logic         r0_ack, r0_rvalid, r1_ack, r1_rvalid;
    logic [127:0] r0_rdata, r1_rdata;
    logic         req_qwen, req_qwrd_bwt, req_wqfull;
    logic [31:0]  req_qwaddr;
    logic         wdq_wen, wdq_wqfull;
    logic [127:0] wdq_wdata;
    logic         rdq_rnext, rdq_rqempty;
    logic [127:0] rdq_rdata;
    logic         rd_orphan;

    int total = 0;
    int fails = 0;

    // Reference model state
    int     tagq[$];
    int     prio;
    bit     m_orphan;
    bit     m_rv0, m_rv1;
    logic [127:0] m_rdata;
    bit     m_post_rst;
    int     m_win;

    // Observed values of the last cycle
    logic         ob_ack0, ob_ack1, ob_qwen, ob_bwt, ob_wen, ob_rnext;
    logic [31:0]  ob_qwaddr;
    logic [127:0] ob_wdata;

    mig_req_arb #(.RDTAG_DEPTH(DEPTH), .ADDR_W(32), .DATA_W(128)) dut (
        .mclk(mclk), .mrst(mrst),
        .r0_req(r0_req), .r0_rd_bwt(r0_rd_bwt), .r0_addr(r0_addr),
        .r0_wdata(r0_wdata), .r0_ack(r0_ack), .r0_rvalid(r0_rvalid),
        .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_rd_bwt(r1_rd_bwt), .r1_addr(r1_addr),
        .r1_wdata(r1_wdata), .r1_ack(r1_ack), .r1_rvalid(r1_rvalid),
        .r1_rdata(r1_rdata),
        .req_qwen(req_qwen), .req_qwaddr(req_qwaddr),
        .req_qwrd_bwt(req_qwrd_bwt), .req_wqfull(req_wqfull),
        .wdq_wen(wdq_wen), .wdq_wdata(wdq_wdata), .wdq_wqfull(wdq_wqfull),
        .rdq_rnext(rdq_rnext), .rdq_rqempty(rdq_rqempty),
        .rdq_rdata(rdq_rdata), .rd_orphan(rd_orphan)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic chk(input string t, input logic [127:0] o,
                       input logic [127:0] e);
        total++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", t, o, e);
        end
    endtask

    // One clock cycle: check combinational outputs against the model,
    // advance the clock, then check registered outputs.
    task automatic cyc();
        bit e0, e1, pop;
        int ptag;
        #2;
        ob_ack0 = r0_ack; ob_ack1 = r1_ack; ob_qwen = req_qwen;
        ob_bwt = req_qwrd_bwt; ob_wen = wdq_wen; ob_rnext = rdq_rnext;
        ob_qwaddr = req_qwaddr; ob_wdata = wdq_wdata;
        if (mrst) begin
            m_win = -1;
            chk("rst_ack0", r0_ack, 0);
            chk("rst_ack1", r1_ack, 0);
            chk("rst_qwen", req_qwen, 0);
            chk("rst_qwaddr", req_qwaddr, 0);
            chk("rst_bwt", req_qwrd_bwt, 0);
            chk("rst_wen", wdq_wen, 0);
            chk("rst_wdata", wdq_wdata, 0);
            chk("rst_rnext", rdq_rnext, 0);
            tagq.delete();
            prio = 0; m_orphan = 0; m_rv0 = 0; m_rv1 = 0;
            m_post_rst = 1;
        end else begin
            e0 = r0_req && !req_wqfull &&
                 (r0_rd_bwt ? (tagq.size() < DEPTH) : !wdq_wqfull);
            e1 = r1_req && !req_wqfull &&
                 (r1_rd_bwt ? (tagq.size() < DEPTH) : !wdq_wqfull);
            if (e0 && e1) m_win = prio;
            else if (e0)  m_win = 0;
            else if (e1)  m_win = 1;
            else          m_win = -1;
            chk("ack0", r0_ack, m_win == 0);
            chk("ack1", r1_ack, m_win == 1);
            chk("qwen", req_qwen, m_win >= 0);
            chk("wen", wdq_wen,
                (m_win == 0 && !r0_rd_bwt) || (m_win == 1 && !r1_rd_bwt));
            if (m_win >= 0) begin
                chk("qwaddr", req_qwaddr, m_win == 0 ? r0_addr : r1_addr);
                chk("bwt", req_qwrd_bwt, m_win == 0 ? r0_rd_bwt : r1_rd_bwt);
                if (wdq_wen)
                    chk("wdata", wdq_wdata, m_win == 0 ? r0_wdata : r1_wdata);
            end
            pop = !rdq_rqempty && tagq.size() > 0;
            chk("rnext", rdq_rnext, pop);
            if (!rdq_rqempty && tagq.size() == 0) m_orphan = 1;
            m_rv0 = 0; m_rv1 = 0;
            if (pop) begin
                ptag = tagq.pop_front();
                m_rdata = rdq_rdata;
                if (ptag == 0) m_rv0 = 1; else m_rv1 = 1;
            end
            if (m_win >= 0) begin
                if ((m_win == 0) ? r0_rd_bwt : r1_rd_bwt) tagq.push_back(m_win);
                prio = 1 - m_win;
            end
            m_post_rst = 0;
        end
        @(posedge mclk);
        #1;
        chk("rvalid0", r0_rvalid, m_rv0);
        chk("rvalid1", r1_rvalid, m_rv1);
        if (m_rv0) chk("rdata0", r0_rdata, m_rdata);
        if (m_rv1) chk("rdata1", r1_rdata, m_rdata);
        if (m_post_rst) begin
            chk("rst_rdata0", r0_rdata, 0);
            chk("rst_rdata1", r1_rdata, 0);
        end
        chk("orphan", rd_orphan, m_orphan);
    endtask

    task automatic do_reset();
        mrst = 1'b1;
        cyc();
        mrst = 1'b0;
    endtask

    task automatic idle_in();
        r0_req = 0; r1_req = 0; req_wqfull = 0; wdq_wqfull = 0;
        rdq_rqempty = 1; rdq_rdata = '0;
    endtask

    initial begin
        int n0, n1;
        mrst = 1; r0_rd_bwt = 1; r1_rd_bwt = 1;
        r0_addr = 32'h100; r1_addr = 32'h200;
        r0_wdata = '0; r1_wdata = '0;
        idle_in();
        @(posedge mclk); #1;

        // Reads from both masters, held through reset
        r0_req = 1; r1_req = 1;
        do_reset();
        do_reset();
        cyc();
        chk("d1_ack0", ob_ack0, 1);
        chk("d1_addr0", ob_qwaddr, 32'h100);
        r0_req = 0;
        cyc();
        chk("d1_ack1", ob_ack1, 1);
        chk("d1_addr1", ob_qwaddr, 32'h200);
        r1_req = 0;
        rdq_rqempty = 0; rdq_rdata = 128'hAAAA;
        cyc();
        chk("d1_beatA_r0", r0_rvalid, 1);
        chk("d1_beatA", r0_rdata, 128'hAAAA);
        rdq_rdata = 128'hBBBB;
        cyc();
        chk("d1_beatB_r1", r1_rvalid, 1);
        chk("d1_beatB", r1_rdata, 128'hBBBB);
        rdq_rqempty = 1;

        // Write held off by a full write-data queue
        r0_req = 1; r0_rd_bwt = 0; r0_addr = 32'h40;
        r0_wdata = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
        wdq_wqfull = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("d2_noack", ob_ack0, 0);
        end
        wdq_wqfull = 0;
        cyc();
        chk("d2_ack", ob_ack0, 1);
        chk("d2_qwen", ob_qwen, 1);
        chk("d2_wen", ob_wen, 1);
        chk("d2_bwt", ob_bwt, 0);
        chk("d2_wdata", ob_wdata, 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF);
        r0_req = 0;

        // Fill the tag FIFO, stall the ninth read, release via one pop
        r0_rd_bwt = 1;
        for (int i = 0; i < DEPTH; i++) begin
            r0_req = 1; r0_addr = 32'h1000 + 32'(i * 16);
            cyc();
            chk("d3_fill", ob_ack0, 1);
        end
        r0_addr = 32'h2000;
        cyc();
        chk("d3_stall", ob_ack0, 0);
        rdq_rqempty = 0; rdq_rdata = 128'h1234;
        cyc();
        chk("d3_popcyc_noack", ob_ack0, 0);
        chk("d3_popcyc_rnext", ob_rnext, 1);
        rdq_rqempty = 1;
        cyc();
        chk("d3_ack_after_pop", ob_ack0, 1);
        r0_req = 0;
        rdq_rqempty = 0;
        for (int i = 0; i < 4 * DEPTH && tagq.size() > 0; i++) begin
            rdq_rdata = 128'h5000 + 128'(i);
            cyc();
        end
        chk("d3_drained", tagq.size(), 0);
        rdq_rqempty = 1;

        // Continuous writes from both masters alternate
        do_reset();
        r0_req = 1; r0_rd_bwt = 0; r1_req = 1; r1_rd_bwt = 0;
        n0 = 0; n1 = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("d4_alt", ob_ack0, (i % 2) == 0);
            n0 += int'(ob_ack0); n1 += int'(ob_ack1);
        end
        chk("d4_n0", n0, 10);
        chk("d4_n1", n1, 10);
        r0_req = 0; r1_req = 0;

        // Orphan read data
        do_reset();
        rdq_rqempty = 0; rdq_rdata = 128'hF00D;
        cyc();
        chk("d5_rnext", ob_rnext, 0);
        chk("d5_orphan", rd_orphan, 1);
        rdq_rqempty = 1;
        for (int i = 0; i < 3; i++) cyc();
        chk("d5_sticky", rd_orphan, 1);
        do_reset();
        chk("d5_cleared", rd_orphan, 0);

        // Reset with three reads outstanding
        r0_rd_bwt = 1; r1_rd_bwt = 1;
        for (int i = 0; i < 3; i++) begin
            r0_req = 1; r0_addr = 32'h300 + 32'(i);
            cyc();
        end
        r0_req = 0;
        r1_req = 1; r1_addr = 32'h400; rdq_rqempty = 0;
        do_reset();
        chk("d6_rst_ack1", ob_ack1, 0);
        chk("d6_rst_rnext", ob_rnext, 0);
        chk("d6_rst_rv0", r0_rvalid, 0);
        rdq_rqempty = 1;
        cyc();
        chk("d6_new_ack1", ob_ack1, 1);
        r1_req = 0;
        rdq_rqempty = 0; rdq_rdata = 128'hC0DE;
        cyc();
        chk("d6_route_r1", r1_rvalid, 1);
        chk("d6_route_r0", r0_rvalid, 0);
        chk("d6_data", r1_rdata, 128'hC0DE);
        cyc();
        chk("d6_count0", rd_orphan, 1);
        rdq_rqempty = 1;
        do_reset();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            if (r0_req && m_win != 0) begin
                if ($urandom_range(9) == 0) r0_req = 0;
            end else begin
                r0_req = ($urandom_range(9) < 6);
                r0_rd_bwt = $urandom_range(1);
                r0_addr = $urandom;
                r0_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            if (r1_req && m_win != 1) begin
                if ($urandom_range(9) == 0) r1_req = 0;
            end else begin
                r1_req = ($urandom_range(9) < 6);
                r1_rd_bwt = $urandom_range(1);
                r1_addr = $urandom;
                r1_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            req_wqfull = ($urandom_range(4) == 0);
            wdq_wqfull = ($urandom_range(4) == 0);
            rdq_rqempty = !(tagq.size() > 0 && $urandom_range(1) == 1);
            rdq_rdata = {$urandom, $urandom, $urandom, $urandom};
            cyc();
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
